// File: rtl/sram_config_loader.sv
// Serial config loader for the LUT/routing SRAM.
// Assembles LSB-first bit stream into words; reads them back serially.
module sram_config_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rb_start,
  input  logic                  cfg_bit,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [ADDR_WIDTH-1:0] sram_waddr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  rb_bit,
  output logic                  rb_valid,
  input  logic                  rb_ready,
  output logic                  busy,
  output logic                  loaded
);

  localparam int BW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST =
    BW'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    IDLE, LOAD, WRITE, RB
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BW-1:0]           bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    loaded_q, loaded_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    loaded_d = loaded_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          addr_d   = '0;
          bitcnt_d = '0;
          loaded_d = 1'b0;
        end else if (rb_start) begin
          state_d  = RB;
          addr_d   = '0;
          bitcnt_d = '0;
        end
      end
      LOAD: begin
        if (cfg_valid) begin
          shift_d[bitcnt_q] = cfg_bit;
          if (bitcnt_q == BIT_LAST) begin
            state_d  = WRITE;
            bitcnt_d = '0;
            waddr_d  = addr_q;
            wdata_d  = shift_d;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        if (addr_q == ADDR_LAST) begin
          state_d  = IDLE;
          addr_d   = '0;
          loaded_d = 1'b1;
        end else begin
          state_d = LOAD;
          addr_d  = addr_q + 1'b1;
        end
      end
      RB: begin
        // raddr steps with the bit wrap so words stream back-to-back
        if (rb_ready) begin
          if (bitcnt_q == BIT_LAST) begin
            bitcnt_d = '0;
            if (addr_q == ADDR_LAST) begin
              state_d = IDLE;
              addr_d  = '0;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      loaded_q <= loaded_d;
    end
  end

  assign cfg_ready  = (state_q == LOAD);
  assign sram_we    = (state_q == WRITE);
  assign rb_valid   = (state_q == RB);
  assign busy       = (state_q != IDLE);
  assign sram_waddr = waddr_q;
  assign sram_wdata = wdata_q;
  assign sram_raddr = addr_q;
  assign loaded     = loaded_q;
  assign rb_bit     = rb_valid & sram_rdata[bitcnt_q];

endmodule
